// File: rtl/mem_arb_bridge.sv
// ---------------------------------------------------------------------------
// mem_arb_bridge
//
// N-channel memory front end. Per-channel address requests are arbitrated
// round-robin onto one external valid/ready request port. Up to
// MAX_OUTSTANDING requests may be in flight. An in-order tag FIFO records
// which channel issued each request, so every memory response goes back
// to its issuer.
//
// Ports
//   clk             clock, all logic on the rising edge
//   rst             asynchronous, active-low reset
//   ch_req_addr     per-channel request address, channel i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   ch_req_valid    per-channel request valid
//   ch_req_ready    per-channel request accepted (only the granted bit can be set)
//   ch_resp_data    response data, broadcast to every channel
//   ch_resp_valid   one-hot response valid for the channel that owns the response
//   ch_resp_ready   per-channel response ready
//   mem_req_addr    external request address
//   mem_req_valid   external request valid
//   mem_req_ready   external request ready
//   mem_resp_data   external response data
//   mem_resp_valid  external response valid
//   mem_resp_ready  external response ready
//   perf_issued     number of issued requests (zero unless MEM_ARB_PERF_EN)
//   perf_stall      cycles with mem_req_valid && !mem_req_ready (zero unless MEM_ARB_PERF_EN)
//
// Configuration
//   MEM_ARB_PERF_EN  when defined, builds the two 32-bit wrapping performance
//                    counters; otherwise both perf ports are tied to zero.
// ---------------------------------------------------------------------------
module mem_arb_bridge #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int CHANNELS        = 2,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [CHANNELS*ADDR_WIDTH-1:0] ch_req_addr,
    input  logic [CHANNELS-1:0]            ch_req_valid,
    output logic [CHANNELS-1:0]            ch_req_ready,
    output logic [DATA_WIDTH-1:0]          ch_resp_data,
    output logic [CHANNELS-1:0]            ch_resp_valid,
    input  logic [CHANNELS-1:0]            ch_resp_ready,
    output logic [ADDR_WIDTH-1:0]          mem_req_addr,
    output logic                           mem_req_valid,
    input  logic                           mem_req_ready,
    input  logic [DATA_WIDTH-1:0]          mem_resp_data,
    input  logic                           mem_resp_valid,
    output logic                           mem_resp_ready,
    output logic [31:0]                    perf_issued,
    output logic [31:0]                    perf_stall
);

    localparam int TW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(MAX_OUTSTANDING);
    localparam logic [PW-1:0] LAST_PTR = PW'(MAX_OUTSTANDING - 1);
    localparam logic [TW-1:0] LAST_CH  = TW'(CHANNELS - 1);

    typedef enum logic {
        ARB_FREE,
        ARB_LOCKED
    } arb_state_e;

    arb_state_e    state_q;
    logic [TW-1:0] grant_q;
    logic [TW-1:0] rr_ptr_q, rr_ptr_d;
    logic [TW-1:0] tag_q [MAX_OUTSTANDING];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic [CHANNELS-1:0] rot_valid;
    logic [TW:0]         scan_sum;
    logic                cand_found;
    logic [TW-1:0]       cand_idx;
    logic [TW-1:0]       grant;
    logic                grant_valid;
    logic                req_fire;
    logic                resp_fire;
    logic                fifo_empty;
    logic [TW-1:0]       head_tag;

    // Rotate the valid vector so that bit 0 is the channel at rr_ptr, then
    // take the lowest set bit; scanning downwards lets the lowest index win.
    always_comb begin
        rot_valid  = CHANNELS'({ch_req_valid, ch_req_valid} >> rr_ptr_q);
        scan_sum   = '0;
        cand_found = 1'b0;
        cand_idx   = '0;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            if (rot_valid[k]) begin
                scan_sum = {1'b0, rr_ptr_q} + (TW+1)'(k);
                if (scan_sum >= (TW+1)'(CHANNELS)) begin
                    scan_sum = scan_sum - (TW+1)'(CHANNELS);
                end
                cand_found = 1'b1;
                cand_idx   = scan_sum[TW-1:0];
            end
        end
    end

    // Request side. A locked grant is held regardless of the scan so the
    // presented address cannot change before the memory accepts it. Issue is
    // gated by the registered count only, so a pop never frees a slot in the
    // same cycle. Reset forces every handshake output low.
    always_comb begin
        grant         = (state_q == ARB_LOCKED) ? grant_q : cand_idx;
        mem_req_valid = rst && (count_q < FULL_CNT) &&
                        ((state_q == ARB_LOCKED) || cand_found);
        req_fire      = mem_req_valid && mem_req_ready;
        mem_req_addr  = '0;
        grant_valid   = 1'b0;
        ch_req_ready  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (grant == TW'(i)) begin
                mem_req_addr    = ch_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                grant_valid     = ch_req_valid[i];
                ch_req_ready[i] = req_fire;
            end
        end
        rr_ptr_d = (grant == LAST_CH) ? '0 : grant + TW'(1);
    end

    // Response side: the FIFO head names the owner of the next response.
    // With an empty FIFO nothing is routed and nothing is accepted.
    always_comb begin
        fifo_empty     = (count_q == '0);
        head_tag       = tag_q[head_q];
        ch_resp_data   = mem_resp_data;
        ch_resp_valid  = '0;
        mem_resp_ready = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (!fifo_empty && (head_tag == TW'(i))) begin
                ch_resp_valid[i] = mem_resp_valid;
                mem_resp_ready   = ch_resp_ready[i];
            end
        end
        resp_fire = mem_resp_valid && mem_resp_ready;
    end

    // Tag FIFO pointer and occupancy next-state; a push and pop together
    // leave the count unchanged while both pointers advance.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (resp_fire) begin
            head_d = (head_q == LAST_PTR) ? '0 : head_q + PW'(1);
        end
        if (req_fire) begin
            tail_d = (tail_q == LAST_PTR) ? '0 : tail_q + PW'(1);
        end
        if (req_fire && !resp_fire) begin
            count_d = count_q + CW'(1);
        end else if (!req_fire && resp_fire) begin
            count_d = count_q - CW'(1);
        end
    end

    // Arbiter FSM: a stalled request locks its grant until it fires, and
    // every fire moves the round-robin pointer past the winner.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ARB_FREE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            case (state_q)
                ARB_FREE: begin
                    if (mem_req_valid && !mem_req_ready) begin
                        state_q <= ARB_LOCKED;
                        grant_q <= cand_idx;
                    end else if (req_fire) begin
                        rr_ptr_q <= rr_ptr_d;
                    end
                end
                ARB_LOCKED: begin
                    if (req_fire) begin
                        state_q  <= ARB_FREE;
                        rr_ptr_q <= rr_ptr_d;
                    end
                end
                default: state_q <= ARB_FREE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Tag storage holds only data qualified by count, so it needs no reset.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            tag_q[tail_q] <= grant;
        end
    end

`ifdef MEM_ARB_PERF_EN
    logic [31:0] issued_q;
    logic [31:0] stall_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            issued_q <= '0;
            stall_q  <= '0;
        end else begin
            if (req_fire) begin
                issued_q <= issued_q + 32'd1;
            end
            if (mem_req_valid && !mem_req_ready) begin
                stall_q <= stall_q + 32'd1;
            end
        end
    end

    assign perf_issued = issued_q;
    assign perf_stall  = stall_q;
`else
    assign perf_issued = '0;
    assign perf_stall  = '0;
`endif

    // A requester that drops valid while its request is locked breaks the
    // hold-until-accepted handshake.
    locked_valid_held: assert property (
        @(posedge clk) disable iff (!rst) (state_q == ARB_LOCKED) |-> grant_valid
    );

endmodule
